// File: rtl/cc_dispatch_ctrl.sv
// cc_dispatch_ctrl: command dispatcher/sequencer for the command-code state machines.
// Takes a two-word RX packet (CSN, CC), runs exactly one command machine via its
// run_sm line under a watchdog, or answers unknown/disabled codes on TX with
// CSN followed by ~CC.
module cc_dispatch_ctrl #(
    parameter int NUM_CMD   = 16,
    parameter int CC_W      = 5,
    parameter int TIMEOUT_W = 24
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [31:0]          rx_tdata,
    input  logic                 rx_tvalid,
    input  logic                 rx_tlast,
    output logic                 rx_tready,
    input  logic [NUM_CMD-1:0]   cmd_enable,
    output logic [NUM_CMD-1:0]   run_sm,
    input  logic [NUM_CMD-1:0]   sm_running,
    input  logic [NUM_CMD-1:0]   sm_done,
    output logic [31:0]          csn,
    output logic [CC_W-1:0]      cc,
    output logic                 payload_pending,
    output logic                 tx_own,
    output logic                 tx_tvalid,
    output logic                 tx_tlast,
    input  logic                 tx_tready,
    output logic                 send_csn,
    output logic                 send_inv_cmd,
    output logic                 busy,
    output logic                 timeout_err,
    output logic                 pkt_err,
    output logic [15:0]          cmd_count
);

    typedef enum logic [2:0] {
        IDLE,
        GET_CC,
        RUN,
        RELEASE,
        ERR_CSN1,
        ERR_CSN2,
        ERR_CC1,
        ERR_CC2
    } state_t;

    // Watchdog value in the last RUN cycle: the increment out of it would hit all-ones.
    localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    state_t               state;
    state_t               nxt;
    logic [TIMEOUT_W-1:0] wd;

    logic [CC_W-1:0]    cc_in;
    logic [NUM_CMD-1:0] cc_in_hot;
    logic [NUM_CMD-1:0] cc_hot;
    logic               cc_in_ok;
    logic               done_sel;
    logic               running_sel;

    logic accept_csn;
    logic accept_cc;
    logic pkt_bad;
    logic done_hit;
    logic expire;

    // One-hot decode of a command code; codes at or above NUM_CMD decode to zero.
    function automatic logic [NUM_CMD-1:0] onehot(input logic [CC_W-1:0] c);
        logic [NUM_CMD-1:0] h;
        h = '0;
        for (int i = 0; i < NUM_CMD; i++) begin
            if (c == CC_W'(i)) h[i] = 1'b1;
        end
        return h;
    endfunction

    assign cc_in       = rx_tdata[CC_W-1:0];
    assign cc_in_hot   = onehot(cc_in);
    assign cc_hot      = onehot(cc);
    // Out-of-range codes decode to zero, so they also fail the enable test.
    assign cc_in_ok    = |(cc_in_hot & cmd_enable);
    // Only the machine selected by the latched code can complete or hold RELEASE.
    assign done_sel    = |(cc_hot & sm_done);
    assign running_sel = |(cc_hot & sm_running);

    // Next-state and event decode; handshakes use the registered rx_tready.
    always_comb begin
        nxt        = state;
        accept_csn = 1'b0;
        accept_cc  = 1'b0;
        pkt_bad    = 1'b0;
        done_hit   = 1'b0;
        expire     = 1'b0;
        case (state)
            IDLE: begin
                if (rx_tvalid && rx_tready) begin
                    if (!rx_tlast) begin
                        accept_csn = 1'b1;
                        nxt        = GET_CC;
                    end else begin
                        pkt_bad = 1'b1;
                    end
                end
            end
            GET_CC: begin
                if (rx_tvalid && rx_tready) begin
                    accept_cc = 1'b1;
                    nxt       = cc_in_ok ? RUN : ERR_CSN1;
                end
            end
            RUN: begin
                // Done takes priority over a watchdog expiry in the same cycle.
                if (done_sel) begin
                    done_hit = 1'b1;
                    nxt      = RELEASE;
                end else if (wd == WD_LAST) begin
                    expire = 1'b1;
                    nxt    = RELEASE;
                end
            end
            RELEASE: begin
                if (!running_sel) nxt = IDLE;
            end
            ERR_CSN1: begin
                if (tx_tready) nxt = ERR_CSN2;
            end
            ERR_CSN2: nxt = ERR_CC1;
            ERR_CC1: begin
                if (tx_tready) nxt = ERR_CC2;
            end
            ERR_CC2: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // State, latched fields and all outputs, registered from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            wd              <= '0;
            csn             <= '0;
            cc              <= '0;
            payload_pending <= 1'b0;
            run_sm          <= '0;
            rx_tready       <= 1'b0;
            tx_own          <= 1'b0;
            tx_tvalid       <= 1'b0;
            tx_tlast        <= 1'b0;
            send_csn        <= 1'b0;
            send_inv_cmd    <= 1'b0;
            busy            <= 1'b0;
            timeout_err     <= 1'b0;
            pkt_err         <= 1'b0;
            cmd_count       <= '0;
        end else begin
            state <= nxt;

            if (accept_csn) csn <= rx_tdata;

            // A leftover payload is only owned while a command is in flight.
            if (accept_cc) begin
                cc              <= cc_in;
                payload_pending <= ~rx_tlast;
            end else if (nxt == IDLE) begin
                payload_pending <= 1'b0;
            end

            // Watchdog counts consecutive RUN cycles starting from zero on entry.
            if (state == RUN && nxt == RUN) wd <= wd + TIMEOUT_W'(1);
            else                            wd <= '0;

            if (nxt == RUN && state == GET_CC) run_sm <= cc_in_hot;
            else if (nxt != RUN)               run_sm <= '0;

            if (done_hit) cmd_count <= cmd_count + 16'd1;

            timeout_err  <= expire;
            pkt_err      <= pkt_bad;
            rx_tready    <= (nxt == IDLE) || (nxt == GET_CC);
            busy         <= (nxt != IDLE);
            tx_own       <= (nxt == ERR_CSN1) || (nxt == ERR_CSN2) ||
                            (nxt == ERR_CC1)  || (nxt == ERR_CC2);
            send_csn     <= (nxt == ERR_CSN1) || (nxt == ERR_CSN2);
            send_inv_cmd <= (nxt == ERR_CC1)  || (nxt == ERR_CC2);
            tx_tvalid    <= (nxt == ERR_CSN2) || (nxt == ERR_CC2);
            tx_tlast     <= (nxt == ERR_CC2);
        end
    end

endmodule

// File: doc/cc_dispatch_ctrl.md
Name: cc_dispatch_ctrl

Overview:
Command dispatcher and sequencer for the command-code state machines (rd_fill and its siblings).
- Accepts command packets from the RX stream: word 1 = CSN, word 2 = CC.
- Latches CSN and CC, then starts exactly one command state machine through its run_sm line.
- Holds that line until the machine reports sm_done, enforces a watchdog timeout, then releases it.
- For unknown or disabled command codes it drives the shared TX stream itself with an error response: CSN followed by the inverted CC, with tlast.

Parameters:
NUM_CMD, 16, number of command slots; CC values 0..NUM_CMD-1 map one-to-one to run_sm bits
CC_W, 5, command code width taken from rx_tdata[CC_W-1:0]
TIMEOUT_W, 24, watchdog counter width; timeout fires at count 2^TIMEOUT_W-1 clocks in RUN

Ports:
clk  in  1  local clock
reset_n  in  1  asynchronous, active-low reset
rx_tdata  in  32  RX command stream data
rx_tvalid  in  1  RX data valid
rx_tlast  in  1  final word of RX packet
rx_tready  out  1  dispatcher accepts the RX word
cmd_enable  in  NUM_CMD  bit i = 1: command slot i is implemented/allowed
run_sm  out  NUM_CMD  one-hot run level to command state machines
sm_running  in  NUM_CMD  per-machine running flag
sm_done  in  NUM_CMD  per-machine one-cycle done pulse
csn  out  32  latched command serial number
cc  out  CC_W  latched command code
payload_pending  out  1  CC word had rx_tlast=0; running machine owns remaining RX words
tx_own  out  1  dispatcher drives TX (the AXIS mux selects dispatcher when 1)
tx_tvalid  out  1  dispatcher TX valid
tx_tlast  out  1  dispatcher TX last
tx_tready  in  1  TX FIFO ready
send_csn  out  1  route CSN to TX
send_inv_cmd  out  1  route ~CC to TX
busy  out  1  not in IDLE
timeout_err  out  1  one-cycle pulse on watchdog expiry
pkt_err  out  1  one-cycle pulse when a CSN word carries rx_tlast=1
cmd_count  out  16  completed commands, wraps 0xFFFF->0

Behaviour:
- Reset (async, reset_n=0): all outputs 0; csn=0, cc=0; state IDLE; watchdog=0. Reset mid-command drops run_sm immediately.
- All outputs are registered, driven from the next state (same cycle the state is entered).
- IDLE: rx_tready=1. On rx_tvalid:
  - rx_tlast=0: latch csn=rx_tdata, go GET_CC.
  - rx_tlast=1: pulse pkt_err, word discarded, stay IDLE.
- GET_CC: rx_tready=1; wait rx_tvalid. Latch cc=rx_tdata[CC_W-1:0] and payload_pending=~rx_tlast.
  - If cc<NUM_CMD and cmd_enable[cc]=1: go RUN.
  - Otherwise: go ERR_CSN1.
  - Bits rx_tdata[31:CC_W] are ignored.
- rx_tready=0 in every state except IDLE and GET_CC.
- RUN: run_sm[cc]=1, all other bits 0; watchdog increments every cycle.
  - On sm_done[cc]=1: cmd_count+1, go RELEASE.
  - If watchdog reaches all-ones before sm_done: pulse timeout_err, go RELEASE; cmd_count is not incremented.
  - If sm_done and expiry occur in the same cycle, done wins: no timeout_err.
  - sm_done on any bit other than cc is ignored.
- RELEASE: run_sm=0; watchdog cleared. Wait for sm_running[cc]=0, then go IDLE and clear payload_pending. Minimum one cycle in RELEASE.
- Error path (tx_own=1 throughout):
  - ERR_CSN1: send_csn=1; wait tx_tready.
  - ERR_CSN2: send_csn=1, tx_tvalid=1, one cycle.
  - ERR_CC1: send_inv_cmd=1; wait tx_tready.
  - ERR_CC2: send_inv_cmd=1, tx_tvalid=1, tx_tlast=1, one cycle; then IDLE.
  - No run_sm bit asserts on the error path; cmd_count is unchanged.
- tx_own, tx_tvalid, send_* are 0 outside the error states. busy=1 in all states except IDLE.
- Back-to-back: the first packet is accepted in the cycle after return to IDLE; the dispatcher handles at most one outstanding command.

Test Plan:
1. Reset release, cmd_enable[8]=1; RX CSN=0x0000_0123 (tlast=0), CC=0x08 (tlast=1) -> run_sm=0x0100 one cycle after CC accepted, csn=0x123, cc=8, payload_pending=0. Pulse sm_done[8] after 50 cycles -> run_sm=0; IDLE once sm_running[8]=0; cmd_count=1.
2. CC=0x1F (NUM_CMD=16) or cmd_enable[3]=0 with CC=3, tx_tready held 0 for 5 cycles -> run_sm stays 0. Exactly two tx_tvalid pulses: the first with send_csn=1, the second with send_inv_cmd=1 and tx_tlast=1. cmd_count unchanged.
3. TIMEOUT_W=4, CC=8, no sm_done -> timeout_err pulses after 15 RUN cycles, run_sm drops, cmd_count unchanged. sm_done and expiry in the same cycle -> no timeout_err, cmd_count+1.
4. CSN word with rx_tlast=1 -> pkt_err one cycle, state IDLE, no run_sm. Then a valid packet is accepted normally.
5. Deassert reset_n during RUN -> run_sm=0 and busy=0 asynchronously. CC word with tlast=0 -> payload_pending=1 and rx_tready=0 until return to IDLE.
6. 65536 completed commands -> cmd_count wraps to 0. A stray sm_done[2] while cc=8 in RUN is ignored.
